m_cache_assoc: RTL and testbench

M_CACHE_ASSOC -- requirements
Module: m_cache_assoc

---
 rtl/m_cache_assoc.sv | 197 +++++++++++++++++++
 tb/tb_m_cache_assoc.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_cache_assoc.sv
// m_cache_assoc: set-associative, write-through / no-allocate CPU cache with round-robin
// replacement and a one-set-per-cycle flush engine.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_req, i_we, i_addr,       CPU request (accepted when i_req && o_ready)
//   i_wdata
//   o_ready                    cache can accept a request (IDLE and no flush pending)
//   o_ack, o_rdata             one-cycle completion pulse, read word while o_ack
//   i_flush                    invalidate-all request, wins over i_req in IDLE
//   o_mreq, o_mwe, o_maddr,    memory request (line refill or word write)
//   o_mwdata
//   i_mack, i_mrdata           memory completion and 128-bit refill line
module m_cache_assoc #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned WAYS        = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_ready,
  output logic                  o_ack,
  output logic [31:0]           o_rdata,
  input  logic                  i_flush,
  output logic                  o_mreq,
  output logic                  o_mwe,
  output logic [ADDR_WIDTH-1:0] o_maddr,
  output logic [31:0]           o_mwdata,
  input  logic                  i_mack,
  input  logic [127:0]          i_mrdata
);

  localparam int unsigned NumSets = 2 ** INDEX_WIDTH;
  localparam int unsigned TagW    = ADDR_WIDTH - INDEX_WIDTH - 4;
  localparam int unsigned WayW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {StIdle, StLookup, StRefill, StWrite, StResp, StFlush} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:2]  addr_q;
  logic                   we_q;
  logic [31:0]            wdata_q;
  logic [WayW-1:0]        victim_q, victim_d;
  logic [INDEX_WIDTH-1:0] flush_idx_q;

  logic [WAYS-1:0]        valid_q [NumSets];
  logic [WayW-1:0]        ptr_q   [NumSets];
  logic [TagW-1:0]        tag_q   [NumSets][WAYS];
  logic [127:0]           line_q  [NumSets][WAYS];

  logic [TagW-1:0]        req_tag;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [1:0]             req_word;
  logic                   hit;
  logic [WayW-1:0]        hit_way;
  logic [31:0]            hit_word, resp_word;
  logic                   accept, refill_done;
  logic [WayW-1:0]        ptr_adv;

  // Byte offset within a word carries no information for a word-wide cache.
  logic unused_addr;
  assign unused_addr = ^i_addr[1:0];

  assign req_tag  = addr_q[ADDR_WIDTH-1:INDEX_WIDTH+4];
  assign req_idx  = addr_q[INDEX_WIDTH+3:4];
  assign req_word = addr_q[3:2];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way wins; round-robin only when the set is full.
  always_comb begin
    victim_d = ptr_q[req_idx];
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim_d = WayW'(w);
    end
  end

  assign hit_word    = line_q[req_idx][hit_way][{req_word, 5'b00000} +: 32];
  assign resp_word   = line_q[req_idx][victim_q][{req_word, 5'b00000} +: 32];
  assign refill_done = (state_q == StRefill) && i_mack;
  assign ptr_adv     = (WAYS > 1) ? ptr_q[req_idx] + 1'b1 : '0;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    o_ready  = 1'b0;
    o_ack    = 1'b0;
    o_rdata  = '0;
    o_mreq   = 1'b0;
    o_mwe    = 1'b0;
    o_maddr  = '0;
    o_mwdata = '0;
    unique case (state_q)
      StIdle: begin
        o_ready = !i_flush;
        if (i_flush) begin
          state_d = StFlush;
        end else if (i_req) begin
          accept  = 1'b1;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (we_q) begin
          state_d = StWrite;
        end else if (hit) begin
          o_ack   = 1'b1;
          o_rdata = hit_word;
          state_d = StIdle;
        end else begin
          state_d = StRefill;
        end
      end
      StRefill: begin
        o_mreq  = 1'b1;
        o_maddr = {addr_q[ADDR_WIDTH-1:4], 4'h0};
        if (i_mack) state_d = StResp;
      end
      StWrite: begin
        o_mreq   = 1'b1;
        o_mwe    = 1'b1;
        o_maddr  = {addr_q, 2'b00};
        o_mwdata = wdata_q;
        if (i_mack) state_d = StResp;
      end
      StResp: begin
        o_ack   = 1'b1;
        o_rdata = we_q ? '0 : resp_word;
        state_d = StIdle;
      end
      StFlush: begin
        if (&flush_idx_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      victim_q    <= '0;
      flush_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= i_addr[ADDR_WIDTH-1:2];
        we_q    <= i_we;
        wdata_q <= i_wdata;
      end
      if ((state_q == StLookup) && !we_q && !hit) victim_q <= victim_d;
      if (state_q == StFlush) flush_idx_q <= flush_idx_q + 1'b1;
      else                    flush_idx_q <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned s = 0; s < NumSets; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (state_q == StFlush) begin
      valid_q[flush_idx_q] <= '0;
      ptr_q[flush_idx_q]   <= '0;
    end else if (refill_done) begin
      valid_q[req_idx][victim_q] <= 1'b1;
      if (&valid_q[req_idx]) ptr_q[req_idx] <= ptr_adv;
    end
  end

  // Tags and line data carry no reset; validity alone qualifies them.
  always_ff @(posedge i_clk) begin
    if (refill_done) begin
      tag_q[req_idx][victim_q]  <= req_tag;
      line_q[req_idx][victim_q] <= i_mrdata;
    end else if ((state_q == StLookup) && we_q && hit) begin
      line_q[req_idx][hit_way][{req_word, 5'b00000} +: 32] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_m_cache_assoc.sv
// tb_m_cache_assoc: scoreboard bench for m_cache_assoc with a word-addressed memory model.
module tb_m_cache_assoc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic         we = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic         flush = 1'b0;
  logic         mack = 1'b0;
  logic [127:0] mrdata = '0;
  logic         ready, ack, mreq, mwe;
  logic [31:0]  rdata, maddr, mwdata;

  always #5 clk = ~clk;

  m_cache_assoc u_dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .i_we     (we),
    .i_addr   (addr),
    .i_wdata  (wdata),
    .o_ready  (ready),
    .o_ack    (ack),
    .o_rdata  (rdata),
    .i_flush  (flush),
    .o_mreq   (mreq),
    .o_mwe    (mwe),
    .o_maddr  (maddr),
    .o_mwdata (mwdata),
    .i_mack   (mack),
    .i_mrdata (mrdata)
  );

  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb_q[$];
  logic [31:0] mem [bit [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    bit [31:0] k;
    k = {a[31:2], 2'b00};
    if (mem.exists(k)) return mem[k];
    return k ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'h0};
    return {mem_rd(b + 32'd12), mem_rd(b + 32'd8), mem_rd(b + 32'd4), mem_rd(b)};
  endfunction

  // One CPU transaction: drive, act as memory, pop the scoreboard on o_ack.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input bit exp_miss, input string nm);
    int          cyc;
    int          lat;
    bit          done;
    bit          saw_mreq;
    exp_t        e;
    logic [31:0] exp_maddr;
    cyc = 0;
    while (!ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready: got %b want 1", nm, ready);
      return;
    end
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = wd;
    e.is_wr = w;
    e.data  = w ? 32'h0 : mem_rd(a);
    sb_q.push_back(e);
    @(negedge clk);
    req   = 1'b0;
    we    = 1'b0;
    addr  = $urandom;
    wdata = $urandom;
    exp_maddr = w ? {a[31:2], 2'b00} : {a[31:4], 4'h0};
    cyc = 1;
    done = 1'b0;
    saw_mreq = 1'b0;
    while (!done && cyc <= 50) begin
      if (ack) begin
        e = sb_q.pop_front();
        if (!e.is_wr) begin
          n_cmp++;
          if (rdata !== e.data) begin
            n_err++;
            $display("FAIL %s rdata: got %h want %h", nm, rdata, e.data);
          end
        end
        n_cmp++;
        if (saw_mreq !== (w || exp_miss)) begin
          n_err++;
          $display("FAIL %s mem_traffic: got %b want %b", nm, saw_mreq, (w || exp_miss));
        end
        if (!w && !exp_miss) begin
          n_cmp++;
          if (cyc != 1) begin
            n_err++;
            $display("FAIL %s hit_latency: got %0d want 1", nm, cyc);
          end
        end
        done = 1'b1;
      end else if (mreq) begin
        saw_mreq = 1'b1;
        n_cmp++;
        if (mwe !== w || maddr !== exp_maddr) begin
          n_err++;
          $display("FAIL %s mreq: got mwe=%b maddr=%h want mwe=%b maddr=%h",
                   nm, mwe, maddr, w, exp_maddr);
        end
        if (w) begin
          n_cmp++;
          if (mwdata !== wd) begin
            n_err++;
            $display("FAIL %s mwdata: got %h want %h", nm, mwdata, wd);
          end
        end
        lat = $urandom_range(0, 3);
        repeat (lat) begin
          @(negedge clk);
          cyc++;
          n_cmp++;
          if (mreq !== 1'b1 || maddr !== exp_maddr) begin
            n_err++;
            $display("FAIL %s mreq_hold: got mreq=%b maddr=%h want 1 %h", nm, mreq, maddr,
                     exp_maddr);
          end
        end
        mack   = 1'b1;
        mrdata = w ? {4{$urandom}} : line_of(a);
        if (w) mem[{a[31:2], 2'b00}] = wd;
        @(negedge clk);
        cyc++;
        mack   = 1'b0;
        mrdata = {4{$urandom}};
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s ack_timeout: got no ack want ack within 50 cycles", nm);
      sb_q.delete();
    end else begin
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0) begin
        n_err++;
        $display("FAIL %s ack_pulse: got %b want 0", nm, ack);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", ready); end
    n_cmp++;
    if (mreq !== 1'b0) begin n_err++; $display("FAIL rst_mreq: got %b want 0", mreq); end
    n_cmp++;
    if (ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", ack); end
    n_cmp++;
    if (maddr !== 32'h0 || mwdata !== 32'h0 || rdata !== 32'h0 || mwe !== 1'b0) begin
      n_err++;
      $display("FAIL rst_outputs: got maddr=%h mwdata=%h rdata=%h mwe=%b want zeros",
               maddr, mwdata, rdata, mwe);
    end
  endtask

  task automatic test_defaults();
    mem[32'h100] = 32'h11;
    mem[32'h104] = 32'h22;
    mem[32'h108] = 32'h33;
    mem[32'h10C] = 32'h44;
    do_req(1'b0, 32'h100, 32'h0, 1'b1, "rd_100_miss");
    do_req(1'b0, 32'h104, 32'h0, 1'b0, "rd_104_hit");
  endtask

  task automatic test_conflicts();
    do_req(1'b0, 32'h1100, 32'h0, 1'b1, "rd_1100_fill_way1");
    do_req(1'b0, 32'h2100, 32'h0, 1'b1, "rd_2100_evict_way0");
    do_req(1'b0, 32'h1100, 32'h0, 1'b0, "rd_1100_hit");
    do_req(1'b0, 32'h100, 32'h0, 1'b1, "rd_100_evicted");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 32'h2100 + 32'(4 * i), 32'h0, 1'b0, "b2b_2100_hit");
    end
    do_req(1'b0, 32'h10C, 32'h0, 1'b0, "b2b_10c_hit");
  endtask

  task automatic test_write_hit();
    do_req(1'b1, 32'h108, 32'hDEAD_BEEF, 1'b0, "wr_108_hit");
    do_req(1'b0, 32'h108, 32'h0, 1'b0, "rd_108_updated");
    do_req(1'b0, 32'h104, 32'h0, 1'b0, "rd_104_neighbour");
  endtask

  task automatic test_write_miss();
    do_req(1'b1, 32'h3000, 32'h1234_5678, 1'b1, "wr_3000_miss");
    do_req(1'b0, 32'h3000, 32'h0, 1'b1, "rd_3000_not_installed");
    do_req(1'b0, 32'h3004, 32'h0, 1'b0, "rd_3004_hit");
  endtask

  task automatic test_spurious_mack();
    @(negedge clk);
    mack = 1'b1;
    mrdata = {4{32'hBAD0_BAD0}};
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (mreq !== 1'b0 || ack !== 1'b0 || ready !== 1'b1) begin
        n_err++;
        $display("FAIL stray_mack: got mreq=%b ack=%b ready=%b want 0 0 1", mreq, ack, ready);
      end
    end
    mack = 1'b0;
    do_req(1'b0, 32'h3008, 32'h0, 1'b0, "rd_3008_after_stray");
  endtask

  task automatic test_flush();
    int cnt;
    bit bad;
    do_req(1'b0, 32'h4FF0, 32'h0, 1'b1, "rd_4ff0_last_set");
    req = 1'b1;
    flush = 1'b1;
    addr = 32'h100;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL flush_ready_prio: got %b want 0", ready); end
    @(negedge clk);
    cnt = 0;
    bad = 1'b0;
    while (ready === 1'b0 && cnt < 1000) begin
      cnt++;
      if (ack !== 1'b0 || mreq !== 1'b0) bad = 1'b1;
      if (cnt < 200) begin
        flush = 1'($urandom_range(0, 1));
      end else begin
        flush = 1'b0;
        req = 1'b0;
      end
      @(negedge clk);
    end
    flush = 1'b0;
    req = 1'b0;
    n_cmp++;
    if (cnt != 256) begin n_err++; $display("FAIL flush_len: got %0d want 256", cnt); end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL flush_quiet: got ack/mreq activity want none"); end
    do_req(1'b0, 32'h100, 32'h0, 1'b1, "flush_100_miss");
    do_req(1'b0, 32'h2100, 32'h0, 1'b1, "flush_2100_miss");
    do_req(1'b0, 32'h3000, 32'h0, 1'b1, "flush_3000_miss");
    do_req(1'b0, 32'h4FF4, 32'h0, 1'b1, "flush_4ff4_miss");
  endtask

  task automatic test_reset_mid();
    int  cyc;
    bit  bad;
    cyc = 0;
    while (!ready && cyc < 50) begin @(negedge clk); cyc++; end
    req  = 1'b1;
    we   = 1'b0;
    addr = 32'h1_0100;
    @(negedge clk);
    req = 1'b0;
    cyc = 0;
    while (!mreq && cyc < 10) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (mreq !== 1'b1) begin n_err++; $display("FAIL midrst_refill: got %b want 1", mreq); end
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mreq !== 1'b0 || ack !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_async: got mreq=%b ack=%b want 0 0", mreq, ack);
    end
    mack = 1'b1;
    mrdata = line_of(32'h1_0100);
    @(negedge clk);
    mack = 1'b0;
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack !== 1'b0 || mreq !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL midrst_no_ack: got activity after reset want none"); end
    do_req(1'b0, 32'h1_0100, 32'h0, 1'b1, "midrst_miss_after");
    do_req(1'b0, 32'h100, 32'h0, 1'b1, "midrst_100_miss");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_defaults();
    test_conflicts();
    test_back_to_back();
    test_write_hit();
    test_write_miss();
    test_spurious_mack();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
